// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: FSM encodings, owner ids and default widths.
package dmem_arbiter_pkg;

  localparam int ARB_ADDR_WIDTH = 10;
  localparam int ARB_DATA_WIDTH = 16;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;
  localparam logic [1:0] ARB_DONE  = 2'd3;

  localparam logic ARB_OWN_PIPE = 1'b0;
  localparam logic ARB_OWN_DBG  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_starve_ctr.sv
// Winner select for the two requesters plus the saturating counter that keeps
// the pipeline port from locking out the debug port.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4,
  localparam int CW = $clog2(STARVE_MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb,
  input  logic req0,
  input  logic req1,
  output logic grant1
);

  logic [CW-1:0] count;
  logic          starved;

  assign starved = (count == CW'(STARVE_MAX));
  assign grant1  = req1 & (~req0 | starved);

  // Only arbitration edges touch the counter; a port-0 win with port 1 idle resets the streak.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (arb) begin
      if (grant1 || !req1)
        count <= '0;
      else if (!starved)
        count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port sequencer for the single-port data memory (port 0 pipeline, port 1 debug/loader).
// Define DMEM_ARB_PERF_EN to add grant and port-1 wait counters.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH = ARB_DATA_WIDTH,
  parameter int READ_LAT   = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                  I_CLOCK,
  input  logic                  I_LOCK,
  input  logic                  I_Req0,
  input  logic                  I_We0,
  input  logic [ADDR_WIDTH-1:0] I_Addr0,
  input  logic [DATA_WIDTH-1:0] I_WrData0,
  input  logic                  I_Req1,
  input  logic                  I_We1,
  input  logic [ADDR_WIDTH-1:0] I_Addr1,
  input  logic [DATA_WIDTH-1:0] I_WrData1,
  output logic                  O_Ack0,
  output logic                  O_Ack1,
  output logic [DATA_WIDTH-1:0] O_RdData,
  output logic                  O_Busy,
  output logic                  O_MemEn,
  output logic                  O_MemWe,
  output logic [ADDR_WIDTH-1:0] O_MemAddr,
  output logic [DATA_WIDTH-1:0] O_MemWrData,
`ifdef DMEM_ARB_PERF_EN
  output logic [15:0]           O_GrantCnt0,
  output logic [15:0]           O_GrantCnt1,
  output logic [15:0]           O_WaitCnt1,
`endif
  input  logic [DATA_WIDTH-1:0] I_MemRdData
);

  localparam int WCW = $clog2(READ_LAT + 1);

  logic [1:0]            state;
  logic                  owner;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [WCW-1:0]        wait_cnt;
  logic                  arb;
  logic                  grant1;

  assign arb = (state == ARB_IDLE) && (I_Req0 || I_Req1);

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk    (I_CLOCK),
    .rst_n  (I_LOCK),
    .arb    (arb),
    .req0   (I_Req0),
    .req1   (I_Req1),
    .grant1 (grant1)
  );

  always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
    if (!I_LOCK) begin
      state     <= ARB_IDLE;
      owner     <= ARB_OWN_PIPE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (arb) begin
            owner   <= grant1 ? ARB_OWN_DBG : ARB_OWN_PIPE;
            we_q    <= grant1 ? I_We1 : I_We0;
            addr_q  <= grant1 ? I_Addr1 : I_Addr0;
            wdata_q <= grant1 ? I_WrData1 : I_WrData0;
            state   <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (we_q) begin
            state <= ARB_DONE;
          end else begin
            wait_cnt <= WCW'(READ_LAT);
            state    <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          // Capture on the edge where the count hits zero, so WAIT spans READ_LAT cycles.
          wait_cnt <= wait_cnt - WCW'(1);
          if (wait_cnt == WCW'(1)) begin
            rd_data_q <= I_MemRdData;
            state     <= ARB_DONE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so a reset clears them without waiting for a clock.
  assign O_MemEn     = (state == ARB_ISSUE);
  assign O_MemWe     = O_MemEn & we_q;
  assign O_MemAddr   = addr_q;
  assign O_MemWrData = wdata_q;
  assign O_RdData    = rd_data_q;
  assign O_Busy      = (state != ARB_IDLE);
  assign O_Ack0      = (state == ARB_DONE) && (owner == ARB_OWN_PIPE);
  assign O_Ack1      = (state == ARB_DONE) && (owner == ARB_OWN_DBG);

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;
  logic [15:0] wait_cnt1;

  always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
    if (!I_LOCK) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      wait_cnt1  <= '0;
    end else begin
      if (arb && !grant1)
        grant_cnt0 <= grant_cnt0 + 16'd1;
      if (arb && grant1)
        grant_cnt1 <= grant_cnt1 + 16'd1;
      if (I_Req1 && !(arb && grant1))
        wait_cnt1 <= wait_cnt1 + 16'd1;
    end
  end

  assign O_GrantCnt0 = grant_cnt0;
  assign O_GrantCnt1 = grant_cnt1;
  assign O_WaitCnt1  = wait_cnt1;
`endif

endmodule
